// File: rtl/start_fetch_seq.sv
// Per-context command fetch sequencer: obtains a context's IP (bus read or cached copy),
// reads the command it points at, writes IP+1 back and presents the command downstream.
module start_fetch_seq #(
  parameter int  AW     = 32,
  parameter int  DW     = 32,
  parameter int  NCTX   = 4,
  parameter int  IP_OFF = 1,
  parameter int  TMO    = 15,
  localparam int CW     = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] ctx,
  input  logic [AW-1:0] base_addr,
  input  logic          flush,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic [DW-1:0] cmd,
  output logic [AW-1:0] cmd_ptr,
  output logic [CW-1:0] cmd_ctx,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          busy,
  output logic          err,
  output logic [2:0]    state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_RD_IP  = 3'd2;
  localparam logic [2:0] S_RD_CMD = 3'd3;
  localparam logic [2:0] S_WR_IP  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ctx_q, ctx_d, ctx_mod;
  logic [AW-1:0] ip_addr_q, ip_addr_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          strobed_q, strobed_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [DW-1:0] cmd_q, cmd_d;
  logic [AW-1:0] cmd_ptr_q, cmd_ptr_d;
  logic [CW-1:0] cmd_ctx_q, cmd_ctx_d;
  logic [NCTX-1:0] ipc_valid_q, ipc_valid_d;
  logic [AW-1:0] ipc_q [NCTX];
  logic          ipc_we;
  logic          ack_ok;

  assign ctx_mod = CW'(32'(ctx) % 32'(NCTX));
  assign ptr_inc = ptr_q + AW'(1);
  // strobed_q marks that this phase's single strobe has gone out; only later acks count.
  assign ack_ok  = bus_ack && strobed_q;

  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    ip_addr_d   = ip_addr_q;
    ptr_d       = ptr_q;
    strobed_d   = strobed_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    cmd_d       = cmd_q;
    cmd_ptr_d   = cmd_ptr_q;
    cmd_ctx_d   = cmd_ctx_q;
    ipc_valid_d = flush ? '0 : ipc_valid_q;
    ipc_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ctx_d     = ctx_mod;
          ip_addr_d = base_addr + AW'(IP_OFF);
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        strobed_d = 1'b0;
        tmo_d     = '0;
        if (bus_gnt) begin
          if (ipc_valid_q[ctx_q]) begin
            ptr_d   = ipc_q[ctx_q];
            state_d = S_RD_CMD;
          end else begin
            state_d = S_RD_IP;
          end
        end
      end
      S_RD_IP, S_RD_CMD, S_WR_IP: begin
        strobed_d = 1'b1;
        tmo_d     = tmo_q + TW'(1);
        if (ack_ok) begin
          strobed_d = 1'b0;
          tmo_d     = '0;
          if (state_q == S_RD_IP) begin
            ptr_d   = bus_rdata[AW-1:0];
            state_d = S_RD_CMD;
          end else if (state_q == S_RD_CMD) begin
            cmd_d     = bus_rdata;
            cmd_ptr_d = ptr_q;
            cmd_ctx_d = ctx_q;
            state_d   = S_WR_IP;
          end else begin
            // Write-back completion overrides a coincident flush for this context only.
            ipc_we             = 1'b1;
            ipc_valid_d[ctx_q] = 1'b1;
            state_d            = S_OUT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d              = 1'b1;
          ipc_valid_d[ctx_q] = 1'b0;
          state_d            = S_ERR;
        end
      end
      // cmd_valid is high throughout OUT with cmd/cmd_ptr/cmd_ctx frozen; the
      // transfer completes on the first rising edge where cmd_ready is also high.
      S_OUT: begin
        if (cmd_ready) state_d = S_IDLE;
      end
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctx_q       <= '0;
      ip_addr_q   <= '0;
      ptr_q       <= '0;
      strobed_q   <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_ptr_q   <= '0;
      cmd_ctx_q   <= '0;
      ipc_valid_q <= '0;
      for (int i = 0; i < NCTX; i++) ipc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      ip_addr_q   <= ip_addr_d;
      ptr_q       <= ptr_d;
      strobed_q   <= strobed_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      cmd_ptr_q   <= cmd_ptr_d;
      cmd_ctx_q   <= cmd_ctx_d;
      ipc_valid_q <= ipc_valid_d;
      if (ipc_we) ipc_q[ctx_q] <= ptr_inc;
    end
  end

  always_comb begin
    bus_req   = (state_q == S_REQ) || (state_q == S_RD_IP) ||
                (state_q == S_RD_CMD) || (state_q == S_WR_IP);
    bus_rd    = ((state_q == S_RD_IP) || (state_q == S_RD_CMD)) && !strobed_q;
    bus_wr    = (state_q == S_WR_IP) && !strobed_q;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      S_RD_IP:  bus_addr = ip_addr_q;
      S_RD_CMD: bus_addr = ptr_q;
      S_WR_IP: begin
        bus_addr  = ip_addr_q;
        bus_wdata = DW'(ptr_inc);
      end
      default: ;
    endcase
  end

  assign cmd       = cmd_q;
  assign cmd_ptr   = cmd_ptr_q;
  assign cmd_ctx   = cmd_ctx_q;
  assign cmd_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_start_fetch_seq.sv
// Bench for start_fetch_seq: memory-backed bus responder plus a per-context IP cache model
// that predicts every bus strobe, the presented command and the start-to-valid latency.
module tb_start_fetch_seq;

  localparam int NCTX = 4;
  localparam int TMO  = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  ctx;
  logic [31:0] base_addr;
  logic        flush, flush_main, flush_resp;
  logic        bus_req, bus_gnt;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] cmd, cmd_ptr;
  logic [1:0]  cmd_ctx;
  logic        cmd_valid, cmd_ready;
  logic        busy, err;
  logic [2:0]  state_o;

  assign flush = flush_main | flush_resp;

  start_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .ctx(ctx), .base_addr(base_addr), .flush(flush),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .cmd(cmd), .cmd_ptr(cmd_ptr), .cmd_ctx(cmd_ctx), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .err(err), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [64:0] exp_q[$];
  logic [64:0] log_q[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // bus memory and responder
  logic [31:0] mem [logic [31:0]];
  int          gnt_delay = 0;
  int          ack_delay = 1;
  bit          stray_en  = 1'b0;
  bit          flush_wr  = 1'b0;
  bit          hold_en   = 1'b0;
  logic [31:0] hold_addr = '0;
  int          req_cnt   = 0;
  int          pend_cnt  = 0;
  bit          pend_wr   = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_data = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  always @(negedge clk) begin
    bus_ack    = 1'b0;
    bus_rdata  = $urandom;
    flush_resp = 1'b0;
    if (rst) begin
      pend_cnt = 0;
      req_cnt  = 0;
      bus_gnt  = 1'b0;
    end else begin
      if (bus_req) begin
        bus_gnt = (req_cnt >= gnt_delay);
        req_cnt++;
      end else begin
        bus_gnt = 1'b0;
        req_cnt = 0;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus_ack = 1'b1;
          if (pend_wr) begin
            mem[pend_addr] = pend_data;
            if (flush_wr) flush_resp = 1'b1;
          end else begin
            bus_rdata = mem_rd(pend_addr);
          end
        end
      end
      if (bus_rd || bus_wr) begin
        log_q.push_back({bus_wr, bus_addr, bus_wdata});
        if (!(bus_rd && hold_en && bus_addr == hold_addr)) begin
          pend_cnt  = ack_delay;
          pend_wr   = bus_wr;
          pend_addr = bus_addr;
          pend_data = bus_wdata;
        end
        if (stray_en) begin
          bus_ack   = 1'b1;
          bus_rdata = $urandom;
        end
      end
    end
  end

  // reference cache model
  bit          m_valid [NCTX];
  logic [31:0] m_ipc   [NCTX];
  logic [31:0] obs_cmd, obs_ptr;
  int          obs_lat;

  // driver tasks
  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; flush_main = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NCTX; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_flush();
    flush_main = 1'b1;
    @(negedge clk);
    flush_main = 1'b0;
    for (int i = 0; i < NCTX; i++) m_valid[i] = 1'b0;
  endtask

  task automatic run_fetch(input int c, input logic [31:0] base, input int gd, input int ad,
                           input int rdl, input bit fw, input bit stray, input bit xstart,
                           input bit rst_out);
    logic [31:0] ip, ptr, e_cmd;
    int lat, exp_lat, nph;
    bit miss, seen_req, req_bad, hold_bad;
    ip   = base + 32'd1;
    miss = !m_valid[c];
    exp_q.delete();
    log_q.delete();
    if (miss) begin
      ptr = mem_rd(ip);
      exp_q.push_back({1'b0, ip, 32'h0});
    end else begin
      ptr = m_ipc[c];
    end
    e_cmd = mem_rd(ptr);
    exp_q.push_back({1'b0, ptr, 32'h0});
    exp_q.push_back({1'b1, ip, ptr + 32'd1});
    nph     = miss ? 3 : 2;
    exp_lat = 2 + gd + nph * (ad + 1);
    gnt_delay = gd; ack_delay = ad; stray_en = stray; flush_wr = fw;
    ctx = 2'(c); base_addr = base; start = 1'b1; cmd_ready = 1'b0;
    lat = 0; seen_req = 1'b0; req_bad = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (bus_req) seen_req = 1'b1;
      else if (seen_req && !cmd_valid) req_bad = 1'b1;
      if (xstart && !cmd_valid && $urandom_range(0, 2) == 0) begin
        start     = 1'b1;
        ctx       = 2'($urandom_range(0, 3));
        base_addr = $urandom;
      end
    end while (!cmd_valid && lat < 300);
    if (!cmd_valid) begin
      chk("cmd_valid_timeout", 65'(cmd_valid), 65'(1));
      stray_en = 1'b0; flush_wr = 1'b0;
      apply_reset();
      return;
    end
    chk("latency", 65'(lat), 65'(exp_lat));
    chk("req_hold", 65'(req_bad), 65'(0));
    chk("req_out", 65'(bus_req), 65'(0));
    chk("cmd", 65'(cmd), 65'(e_cmd));
    chk("cmd_ptr", 65'(cmd_ptr), 65'(ptr));
    chk("cmd_ctx", 65'(cmd_ctx), 65'(c));
    obs_cmd = cmd; obs_ptr = cmd_ptr; obs_lat = lat;
    if (!rst_out) begin
      hold_bad = 1'b0;
      if (rdl == 0) cmd_ready = 1'b1;
      for (int k = 0; k < rdl; k++) begin
        @(negedge clk);
        if (!cmd_valid || cmd !== e_cmd || cmd_ptr !== ptr || cmd_ctx !== 2'(c)) hold_bad = 1'b1;
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("hold", 65'(hold_bad), 65'(0));
      chk("done_valid", 65'(cmd_valid), 65'(0));
      chk("done_busy", 65'(busy), 65'(0));
    end
    chk("n_strobes", 65'(log_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk("strobe", log_q[i], exp_q[i]);
    if (fw) for (int i = 0; i < NCTX; i++) m_valid[i] = 1'b0;
    m_valid[c] = 1'b1;
    m_ipc[c]   = ptr + 32'd1;
    stray_en = 1'b0; flush_wr = 1'b0;
    if (rst_out) begin
      apply_reset();
      chk("rst_out_valid", 65'(cmd_valid), 65'(0));
    end
  endtask

  task automatic run_timeout(input int c, input logic [31:0] base);
    logic [31:0] ip, ptr;
    int k, guard;
    bit seen, miss;
    ip   = base + 32'd1;
    miss = !m_valid[c];
    ptr  = miss ? mem_rd(ip) : m_ipc[c];
    hold_en = 1'b1; hold_addr = ptr; gnt_delay = 0; ack_delay = 1;
    log_q.delete();
    ctx = 2'(c); base_addr = base; start = 1'b1;
    guard = 0; seen = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      seen = bus_rd && (bus_addr == ptr);
    end while (!seen && guard < 50);
    chk("tmo_strobe", 65'(seen), 65'(1));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err && k < 40);
    chk("tmo_cycles", 65'(k), 65'(TMO));
    chk("tmo_req", 65'(bus_req), 65'(0));
    chk("tmo_busy", 65'(busy), 65'(1));
    chk("tmo_valid", 65'(cmd_valid), 65'(0));
    repeat (10) @(negedge clk);
    chk("err_sticky", 65'(err), 65'(1));
    chk("tmo_quiet", 65'(log_q.size()), 65'(miss ? 2 : 1));
    hold_en = 1'b0;
    apply_reset();
    chk("err_clear", 65'(err), 65'(0));
  endtask

  // stimulus
  initial begin
    int          rc, rgd, rad, rrdl;
    bit          rfw, rstray, rx;
    logic [31:0] rb;
    logic [64:0] ent;
    rst = 1'b1; start = 1'b0; ctx = '0; base_addr = '0; flush_main = 1'b0; cmd_ready = 1'b0;
    for (int i = 0; i < NCTX; i++) begin m_valid[i] = 1'b0; m_ipc[i] = '0; end
    mem[32'h101]  = 32'h200;  mem[32'h200] = 32'hCAFE; mem[32'h201] = 32'hBEEF;
    mem[32'h301]  = 32'hFFFF_FFFF;
    mem[32'h401]  = 32'h4400; mem[32'h701] = 32'h7700;
    mem[32'h1001] = 32'h1800;
    apply_reset();
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_err", 65'(err), 65'(0));
    chk("rst_valid", 65'(cmd_valid), 65'(0));
    chk("rst_req", 65'(bus_req), 65'(0));
    chk("rst_rd", 65'(bus_rd), 65'(0));
    chk("rst_wr", 65'(bus_wr), 65'(0));
    chk("rst_addr", 65'(bus_addr), 65'(0));
    chk("rst_wdata", 65'(bus_wdata), 65'(0));
    chk("rst_cmd", 65'(cmd), 65'(0));
    chk("rst_cmd_ptr", 65'(cmd_ptr), 65'(0));
    chk("rst_cmd_ctx", 65'(cmd_ctx), 65'(0));

    // cache miss with zero-wait bus
    run_fetch(0, 32'h100, 0, 1, 0, 0, 0, 0, 0);
    chk("miss_lat8", 65'(obs_lat), 65'(8));
    chk("miss_cmd", 65'(obs_cmd), 65'(32'hCAFE));
    chk("miss_ptr", 65'(obs_ptr), 65'(32'h200));
    // cache hit, then flush forces an IP re-read
    run_fetch(0, 32'h100, 0, 1, 0, 0, 0, 0, 0);
    chk("hit_cmd", 65'(obs_cmd), 65'(32'hBEEF));
    chk("hit_nstrobe", 65'(log_q.size()), 65'(2));
    do_flush();
    run_fetch(0, 32'h100, 0, 1, 0, 0, 0, 0, 0);
    chk("flush_reread", 65'(log_q.size()), 65'(3));
    // grant and ack wait states, downstream backpressure, ignored starts
    run_fetch(1, 32'h1000, 3, 3, 4, 0, 0, 1, 0);
    // IP wrap and independent contexts
    run_fetch(3, 32'h300, 0, 1, 0, 0, 0, 0, 0);
    ent = log_q[log_q.size() - 1];
    chk("wrap_wdata", 65'(ent[31:0]), 65'(0));
    run_fetch(1, 32'h1000, 0, 1, 1, 0, 0, 0, 0);
    chk("ctx1_hit", 65'(log_q.size()), 65'(2));
    run_fetch(3, 32'h300, 0, 1, 0, 0, 0, 0, 0);
    chk("ctx3_hit", 65'(log_q.size()), 65'(2));
    run_fetch(1, 32'h1000, 0, 1, 0, 1, 0, 0, 0);
    run_fetch(3, 32'h300, 0, 1, 0, 0, 0, 0, 0);
    chk("flushwr_ctx3_miss", 65'(log_q.size()), 65'(3));
    run_fetch(1, 32'h1000, 0, 1, 0, 0, 0, 0, 0);
    chk("flushwr_ctx1_hit", 65'(log_q.size()), 65'(2));
    // bus timeout
    run_timeout(2, 32'h700);
    // reset while waiting for a command read
    log_q.delete();
    gnt_delay = 0; ack_delay = 3;
    ctx = 2'd2; base_addr = 32'h400; start = 1'b1;
    rc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      rc++;
    end while (log_q.size() < 2 && rc < 50);
    chk("mid_seen", 65'(log_q.size()), 65'(2));
    apply_reset();
    repeat (10) @(negedge clk);
    chk("mid_quiet", 65'(log_q.size()), 65'(2));
    chk("mid_busy", 65'(busy), 65'(0));
    run_fetch(2, 32'h400, 0, 1, 0, 0, 0, 0, 0);
    chk("mid_reread", 65'(log_q.size()), 65'(3));
    // reset after the write-back was acknowledged still empties the cache
    run_fetch(1, 32'h1000, 0, 1, 0, 0, 0, 0, 1);
    run_fetch(1, 32'h1000, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_out_reread", 65'(log_q.size()), 65'(3));

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      rc     = $urandom_range(0, 3);
      rb     = $urandom;
      rgd    = $urandom_range(0, 3);
      rad    = $urandom_range(1, 3);
      rrdl   = $urandom_range(0, 3);
      rfw    = ($urandom_range(0, 3) == 0);
      rstray = 1'($urandom_range(0, 1));
      rx     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) do_flush();
      run_fetch(rc, rb, rgd, rad, rrdl, rfw, rstray, rx, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
